// File: rtl/motor_pwm_driver.sv
// N-channel signed-command PWM H-bridge driver with period-boundary updates,
// reversal dead time, per-channel stop and command watchdog.
module motor_pwm_driver #(
  parameter int NUM_CHN      = 4,
  parameter int CHN_WIDTH    = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int PWM_PERIOD   = 1000,
  parameter int DEAD_PERIODS = 2,
  parameter int WDT_PERIODS  = 50
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid_i,
  input  logic [CHN_WIDTH-1:0]  cmd_chn_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic [NUM_CHN-1:0]    stop_i,
  output logic [NUM_CHN-1:0]    motor_in_1_o,
  output logic [NUM_CHN-1:0]    motor_in_2_o,
  output logic [NUM_CHN-1:0]    wdt_trip_o,
  output logic                  cmd_err_o
);

  localparam int DCW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
  localparam int WCW = (WDT_PERIODS > 0) ? $clog2(WDT_PERIODS + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] PERIOD_M  = DATA_WIDTH'(PWM_PERIOD);
  localparam logic [DATA_WIDTH-1:0] LAST_CNT  = DATA_WIDTH'(PWM_PERIOD - 1);
  localparam logic [DCW-1:0]        DEAD_INIT = DCW'(DEAD_PERIODS);
  localparam logic [WCW-1:0]        WDT_MAX   = WCW'(WDT_PERIODS);
  localparam logic [WCW-1:0]        WDT_LAST  = WCW'(WDT_PERIODS - 1);
  localparam logic [31:0]           NUM_CHN_L = 32'(NUM_CHN);

  // IDLE: coast | RUN: drive active duty | DEAD: coast dead_q more periods before reversing
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_e;

  logic [DATA_WIDTH-1:0] pwm_cnt_q;
  logic                  boundary;

  logic                  cmd_rev;
  logic [DATA_WIDTH-1:0] cmd_abs;
  logic [DATA_WIDTH-1:0] cmd_mag;
  logic [31:0]           chn_ext;
  logic                  chn_ok;
  logic [NUM_CHN-1:0]    wr_sel;

  logic [NUM_CHN-1:0]    tgt_rev_q, tgt_rev_d;
  logic [DATA_WIDTH-1:0] tgt_mag_q [NUM_CHN];
  logic [DATA_WIDTH-1:0] tgt_mag_d [NUM_CHN];
  logic [WCW-1:0]        wdt_cnt_q [NUM_CHN];
  logic [WCW-1:0]        wdt_cnt_d [NUM_CHN];
  logic [NUM_CHN-1:0]    trip_q, trip_d;
  logic                  cmd_err_q;

  state_e                state_q   [NUM_CHN];
  logic [NUM_CHN-1:0]    act_rev_q;
  logic [DATA_WIDTH-1:0] act_mag_q [NUM_CHN];
  logic [DCW-1:0]        dead_q    [NUM_CHN];
  logic [NUM_CHN-1:0]    in1_q, in2_q;

  assign boundary = (pwm_cnt_q == LAST_CNT);
  assign chn_ext  = 32'(cmd_chn_i);

  // Most-negative input yields 2^(W-1) as an unsigned magnitude, then saturates.
  always_comb begin
    cmd_rev = cmd_data_i[DATA_WIDTH-1];
    cmd_abs = cmd_rev ? (~cmd_data_i + DATA_WIDTH'(1)) : cmd_data_i;
    cmd_mag = (cmd_abs > PERIOD_M) ? PERIOD_M : cmd_abs;
    chn_ok  = (chn_ext < NUM_CHN_L);
    wr_sel  = '0;
    for (int k = 0; k < NUM_CHN; k++) begin
      wr_sel[k] = cmd_valid_i && chn_ok && (cmd_chn_i == CHN_WIDTH'(k));
    end
  end

  // A command on the same cycle as watchdog expiry takes priority.
  always_comb begin
    tgt_rev_d = tgt_rev_q;
    trip_d    = trip_q;
    for (int k = 0; k < NUM_CHN; k++) begin
      tgt_mag_d[k] = tgt_mag_q[k];
      wdt_cnt_d[k] = wdt_cnt_q[k];
      if (wr_sel[k]) begin
        tgt_rev_d[k] = cmd_rev;
        tgt_mag_d[k] = cmd_mag;
        wdt_cnt_d[k] = '0;
        trip_d[k]    = 1'b0;
      end else if ((WDT_PERIODS > 0) && boundary && (wdt_cnt_q[k] != WDT_MAX)) begin
        wdt_cnt_d[k] = wdt_cnt_q[k] + WCW'(1);
        if (wdt_cnt_q[k] == WDT_LAST) begin
          tgt_mag_d[k] = '0;
          trip_d[k]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt_q <= '0;
      tgt_rev_q <= '0;
      trip_q    <= '0;
      cmd_err_q <= 1'b0;
      for (int k = 0; k < NUM_CHN; k++) begin
        tgt_mag_q[k] <= '0;
        wdt_cnt_q[k] <= '0;
      end
    end else begin
      pwm_cnt_q <= boundary ? '0 : pwm_cnt_q + DATA_WIDTH'(1);
      tgt_rev_q <= tgt_rev_d;
      trip_q    <= trip_d;
      cmd_err_q <= cmd_valid_i && !chn_ok;
      for (int k = 0; k < NUM_CHN; k++) begin
        tgt_mag_q[k] <= tgt_mag_d[k];
        wdt_cnt_q[k] <= wdt_cnt_d[k];
      end
    end
  end

  // Transitions sample tgt_*_q, so a write on the boundary cycle waits one period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_rev_q <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      for (int k = 0; k < NUM_CHN; k++) begin
        state_q[k]   <= ST_IDLE;
        act_mag_q[k] <= '0;
        dead_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CHN; k++) begin
        in1_q[k] <= !stop_i[k] && (state_q[k] == ST_RUN) && !act_rev_q[k] &&
                    (pwm_cnt_q < act_mag_q[k]);
        in2_q[k] <= !stop_i[k] && (state_q[k] == ST_RUN) && act_rev_q[k] &&
                    (pwm_cnt_q < act_mag_q[k]);
        if (stop_i[k]) begin
          state_q[k] <= ST_IDLE;
        end else if (boundary) begin
          case (state_q[k])
            ST_IDLE: begin
              if (tgt_mag_q[k] != '0) begin
                state_q[k]   <= ST_RUN;
                act_rev_q[k] <= tgt_rev_q[k];
                act_mag_q[k] <= tgt_mag_q[k];
              end
            end
            ST_RUN: begin
              if (tgt_mag_q[k] == '0) begin
                state_q[k] <= ST_IDLE;
              end else if ((tgt_rev_q[k] == act_rev_q[k]) || (DEAD_PERIODS == 0)) begin
                act_rev_q[k] <= tgt_rev_q[k];
                act_mag_q[k] <= tgt_mag_q[k];
              end else begin
                state_q[k] <= ST_DEAD;
                dead_q[k]  <= DEAD_INIT;
              end
            end
            ST_DEAD: begin
              if (dead_q[k] == DCW'(1)) begin
                if (tgt_mag_q[k] == '0) begin
                  state_q[k] <= ST_IDLE;
                end else begin
                  state_q[k]   <= ST_RUN;
                  act_rev_q[k] <= tgt_rev_q[k];
                  act_mag_q[k] <= tgt_mag_q[k];
                end
              end else begin
                dead_q[k] <= dead_q[k] - DCW'(1);
              end
            end
            default: state_q[k] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign motor_in_1_o = in1_q;
  assign motor_in_2_o = in2_q;
  assign wdt_trip_o   = trip_q;
  assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: duty table, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_motor_pwm_driver;

  localparam int NCH = 4, CW = 3, DW = 16, P = 10, DEADP = 2, WDTP = 5;
  localparam int HN = 128;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           cmd_valid = 1'b0;
  logic [CW-1:0]  cmd_chn = '0;
  logic [DW-1:0]  cmd_data = '0;
  logic [NCH-1:0] stop = '0;
  logic [NCH-1:0] in1, in2, trip;
  logic           err;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .NUM_CHN(NCH), .CHN_WIDTH(CW), .DATA_WIDTH(DW),
    .PWM_PERIOD(P), .DEAD_PERIODS(DEADP), .WDT_PERIODS(WDTP)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid_i(cmd_valid), .cmd_chn_i(cmd_chn),
    .cmd_data_i(cmd_data), .stop_i(stop), .motor_in_1_o(in1),
    .motor_in_2_o(in2), .wdt_trip_o(trip), .cmd_err_o(err)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [NCH-1:0] h_in1 [HN];
  logic [NCH-1:0] h_in2 [HN];
  logic [NCH-1:0] h_trip [HN];
  logic           h_err [HN];

  // Reference model: signed duty ints; act==0 idle, coast>0 reversal coast.
  int m_cnt;
  int m_tgt [NCH];
  int m_act [NCH];
  int m_coast [NCH];
  int m_wdt [NCH];
  logic [NCH-1:0] e_in1, e_in2, e_trip;
  logic e_err;

  function automatic int decode(logic [DW-1:0] d);
    int v, m;
    v = $signed(d);
    m = (v < 0) ? -v : v;
    if (m > P) m = P;
    return (v < 0) ? -m : m;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < NCH; k++) begin
      m_tgt[k] = 0; m_act[k] = 0; m_coast[k] = 0; m_wdt[k] = 0;
    end
    e_in1 = '0; e_in2 = '0; e_trip = '0; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit bnd;
    bit wr;
    bnd = (m_cnt == P - 1);
    e_err = cmd_valid && (int'(cmd_chn) >= NCH);
    for (int k = 0; k < NCH; k++) begin
      e_in1[k] = !stop[k] && m_coast[k] == 0 && m_act[k] > 0 && m_cnt < m_act[k];
      e_in2[k] = !stop[k] && m_coast[k] == 0 && m_act[k] < 0 && m_cnt < -m_act[k];
      if (stop[k]) begin
        m_act[k] = 0; m_coast[k] = 0;
      end else if (bnd) begin
        if (m_coast[k] > 0) begin
          if (m_coast[k] == 1) begin m_coast[k] = 0; m_act[k] = m_tgt[k]; end
          else m_coast[k]--;
        end else if (m_act[k] == 0 || m_tgt[k] == 0) begin
          m_act[k] = m_tgt[k];
        end else if ((m_tgt[k] > 0) == (m_act[k] > 0) || DEADP == 0) begin
          m_act[k] = m_tgt[k];
        end else begin
          m_act[k] = 0; m_coast[k] = DEADP;
        end
      end
      wr = cmd_valid && int'(cmd_chn) == k;
      if (wr) begin
        m_tgt[k] = decode(cmd_data); m_wdt[k] = 0; e_trip[k] = 1'b0;
      end else if (bnd && m_wdt[k] < WDTP) begin
        m_wdt[k]++;
        if (m_wdt[k] == WDTP) begin m_tgt[k] = 0; e_trip[k] = 1'b1; end
      end
    end
    m_cnt = bnd ? 0 : m_cnt + 1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("model", 32'({in1, in2, trip, err}), 32'({e_in1, e_in2, e_trip, e_err}));
    chk("exclusive", 32'(in1 & in2), 32'd0);
    if (cyc < HN) begin
      h_in1[cyc] = in1; h_in2[cyc] = in2; h_trip[cyc] = trip; h_err[cyc] = err;
    end
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic send(int ch, logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_chn = CW'(ch); cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; cmd_valid = 1'b0; stop = '0;
    #1;
    model_reset();
    chk("async_reset", 32'({in1, in2, trip, err}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    h_in1[0] = in1; h_in2[0] = in2; h_trip[0] = trip; h_err[0] = err;
  endtask

  function automatic int cnt1(int ch, int a, int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(h_in1[i][ch]);
    return s;
  endfunction

  function automatic int cnt2(int ch, int a, int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(h_in2[i][ch]);
    return s;
  endfunction

  typedef struct {
    int            chn;
    logic [DW-1:0] data;
    int            hi1;
    int            hi2;
  } vec_t;

  vec_t vt [9];

  initial begin
    int others;
    int sb;
    vt[0] = '{0, 16'd3,    3,  0};
    vt[1] = '{1, 16'h8000, 0,  10};
    vt[2] = '{2, 16'd4,    4,  0};
    vt[3] = '{3, 16'hFFFF, 0,  1};
    vt[4] = '{0, 16'd0,    0,  0};
    vt[5] = '{1, 16'd10,   10, 0};
    vt[6] = '{2, 16'hFFF7, 0,  9};
    vt[7] = '{3, 16'h7FFF, 10, 0};
    vt[8] = '{0, 16'd11,   10, 0};

    // Steady-state duty per command; window 21..30 reflects one full period.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      send(vt[v].chn, vt[v].data);
      run_to(30);
      chk("tbl_in1", 32'(cnt1(vt[v].chn, 21, 30)), 32'(vt[v].hi1));
      chk("tbl_in2", 32'(cnt2(vt[v].chn, 21, 30)), 32'(vt[v].hi2));
      others = 0;
      for (int k = 0; k < NCH; k++)
        if (k != vt[v].chn) others += cnt1(k, 21, 30) + cnt2(k, 21, 30);
      chk("tbl_others", 32'(others), 32'd0);
    end

    // Reversal: full reverse, then +4 -> two coast periods, then 4/10 forward.
    do_reset();
    send(1, 16'h8000);
    run_to(20);
    send(1, 16'd4);
    run_to(60);
    chk("rev_last_in2", 32'(h_in2[30][1]), 32'd1);
    chk("rev_coast", 32'(cnt1(1, 31, 50) + cnt2(1, 31, 50)), 32'd0);
    chk("rev_fwd_first", 32'(h_in1[51][1]), 32'd1);
    chk("rev_fwd_duty", 32'(cnt1(1, 51, 60)), 32'd4);
    chk("rev_fwd_in2", 32'(cnt2(1, 51, 60)), 32'd0);

    // Mid-period update waits for the next period start.
    do_reset();
    send(2, 16'd2);
    run_to(24);
    send(2, 16'd5);
    run_to(40);
    chk("mid_old", 32'(cnt1(2, 21, 30)), 32'd2);
    chk("mid_new", 32'(cnt1(2, 31, 40)), 32'd5);
    chk("mid_edge", 32'({h_in1[30][2], h_in1[31][2]}), 32'b01);

    // Stop with a command stored during stop.
    do_reset();
    send(0, 16'd6);
    run_to(24);
    chk("stop_pre", 32'(h_in1[24][0]), 32'd1);
    stop[0] = 1'b1;
    run_to(30);
    send(0, 16'd7);
    run_to(35);
    stop[0] = 1'b0;
    run_to(50);
    chk("stop_low", 32'(cnt1(0, 25, 40) + cnt2(0, 25, 40)), 32'd0);
    chk("stop_resume", 32'(cnt1(0, 41, 50)), 32'd7);

    // Watchdog expiry, command-wins race, re-arm, bad channel pulses.
    do_reset();
    send(3, 16'd2);
    run_to(49);
    send(1, 16'd3);
    run_to(72);
    send(3, 16'd2);
    run_to(80);
    send(5, 16'd9);
    run_to(85);
    send(4, 16'd1);
    run_to(90);
    chk("wdt_pre", 32'(h_trip[49][3]), 32'd0);
    chk("wdt_trip", 32'(h_trip[50][3]), 32'd1);
    chk("wdt_last_duty", 32'(cnt1(3, 51, 60)), 32'd2);
    chk("wdt_zeroed", 32'(cnt1(3, 61, 70)), 32'd0);
    chk("wdt_race_ch1", 32'(h_trip[50][1]), 32'd0);
    chk("wdt_idle_ch0", 32'(h_trip[50][0]), 32'd1);
    chk("bnd_cmd_wait", 32'(cnt1(1, 51, 60)), 32'd0);
    chk("bnd_cmd_duty", 32'(cnt1(1, 61, 70)), 32'd3);
    chk("wdt_sticky", 32'(h_trip[72][3]), 32'd1);
    chk("wdt_clear", 32'(h_trip[73][3]), 32'd0);
    chk("err_pulse", 32'({h_err[80], h_err[81], h_err[82]}), 32'b010);
    chk("err_chn4", 32'(h_err[86]), 32'd1);
    chk("err_no_effect", 32'(cnt1(1, 81, 90)), 32'd3);
    chk("rearm_duty", 32'(cnt1(3, 81, 90)), 32'd2);

    // Randomized traffic against the model, with one mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b1;
        cmd_chn = CW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) cmd_data = DW'(int'($urandom_range(0, 24)) - 12);
        else cmd_data = DW'($urandom());
      end else begin
        cmd_valid = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) begin
        sb = int'($urandom_range(0, NCH - 1));
        stop[sb] = ~stop[sb];
      end
      tick();
    end
    cmd_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

N-channel signed-command PWM H-bridge driver, parametrised successor to the fixed 4-motor output stage. Takes channel-addressed signed duty commands from the UART controller or the PID core, and produces one IN1/IN2 pair per motor. Adds glitch-free period-boundary updates, direction-reversal dead time, per-channel stop and a per-channel command watchdog. Sits between the command source and the motor driver pins in `top`.

## Interface
- `NUM_CHN`, 4, number of motor channels (1..8)
- `CHN_WIDTH`, 3, width of channel index
- `DATA_WIDTH`, 16, width of signed duty command
- `PWM_PERIOD`, 1000, PWM period in clk cycles (2..2^DATA_WIDTH-1)
- `DEAD_PERIODS`, 2, full PWM periods of coast on direction reversal (0 = none)
- `WDT_PERIODS`, 50, PWM periods without a command before a channel is zeroed (0 = disabled)

- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous active-low reset
- `cmd_valid_i`  in  1  command strobe, one-cycle, no backpressure
- `cmd_chn_i`  in  CHN_WIDTH  target channel
- `cmd_data_i`  in  DATA_WIDTH  signed two's-complement duty; +fwd, -rev, 0 coast
- `stop_i`  in  NUM_CHN  per-channel stop, level-sensitive
- `motor_in_1_o`  out  NUM_CHN  forward PWM pin per channel
- `motor_in_2_o`  out  NUM_CHN  reverse PWM pin per channel
- `wdt_trip_o`  out  NUM_CHN  sticky watchdog-tripped flag per channel
- `cmd_err_o`  out  1  one-cycle pulse: command to nonexistent channel

## Operation
- Shared counter `pwm_cnt` counts 0..PWM_PERIOD-1, wraps to 0. Boundary = cycle where `pwm_cnt == PWM_PERIOD-1`.
- Command decode: magnitude = |cmd_data_i|, most-negative value maps to max positive; magnitude saturates to PWM_PERIOD. Direction = sign; zero magnitude = coast.
- Valid command with `cmd_chn_i < NUM_CHN` writes channel target register (dir, mag), clears that channel's watchdog counter and `wdt_trip_o` bit. `cmd_chn_i >= NUM_CHN`: no state change, `cmd_err_o` = 1 next cycle.
- Per-channel state machine, evaluated only at boundary, sampling target register value before any same-cycle write:
  - IDLE: target mag 0 -> stay; else -> RUN with active := target.
  - RUN: target mag 0 -> IDLE; same dir -> RUN, active mag := target mag; opposite dir -> DEAD with dead_cnt := DEAD_PERIODS (if DEAD_PERIODS = 0 go straight to RUN with new dir/mag).
  - DEAD: outputs coast; dead_cnt decrements each boundary; on boundary where dead_cnt = 1 -> load current target (IDLE if mag 0, else RUN).
- Output per channel (registered): `in_1 = RUN & dir_fwd & (pwm_cnt < active_mag)`, `in_2 = RUN & dir_rev & (pwm_cnt < active_mag)`. IN1 and IN2 never high together.
- mag = 0: pin never high; mag = PWM_PERIOD: pin high whole period.
- Stop: `stop_i[k]` high forces both pins of channel k low on the next clock edge regardless of state, and forces state to IDLE. Target register keeps being written by commands. After stop falls, channel re-enters via IDLE at next boundary (no dead time required, IDLE coasted).
- Watchdog (WDT_PERIODS > 0): per-channel counter increments each boundary, saturating; reaching WDT_PERIODS clears target mag to 0 and sets `wdt_trip_o[k]`. Channel then goes to IDLE at following boundary.

## Timing
- Reset: `pwm_cnt` 0, all targets/actives 0, all states IDLE, all counters 0; all outputs (`motor_in_*_o`, `wdt_trip_o`, `cmd_err_o`) 0.
- Reset mid-period or mid-DEAD: everything returns to reset values asynchronously; pins low immediately.
- Command at cycle t: target valid at t+1; takes effect at first boundary at or after t+1; pins reflect new duty from the cycle after `pwm_cnt` returns to 0.
- Pin latency: pin value at cycle n+1 reflects compare at `pwm_cnt` value of cycle n.
- Command on a boundary cycle: not used by that boundary; applied at the next one.
- Simultaneous command and watchdog expiry on same channel: command wins, trip flag not set.
- Simultaneous stop and command: command stored, pins low.

## Test plan
- Bench params PWM_PERIOD=10, DEAD_PERIODS=2, WDT_PERIODS=5. Reset -> all outputs 0; cmd ch0 = +3 -> ch0 IN1 high 3 of every 10 cycles, IN2 stays 0, other channels 0.
- Cmd ch1 = -32768 -> IN2 high all 10 cycles (saturation); then cmd ch1 = +4 -> exactly 2 full periods both pins low, then IN1 high 4/10.
- Cmd ch2 = +5 mid-period -> current period unchanged, new duty begins exactly at next `pwm_cnt` = 0 (+1 cycle pin latency).
- Ch0 running +6, assert stop_i[0] -> pins low next cycle; deassert -> duty 6/10 resumes from next boundary.
- Ch3 = +2 then no commands -> after 5 boundaries `wdt_trip_o[3]`=1, pins 0 next period; new cmd ch3 = +2 clears trip.
- Cmd chn = 5 -> `cmd_err_o` one-cycle pulse, no channel output changes.
